// File: rtl/dram_stream_reader.sv
// rtl/dram_stream_reader.sv - reads a strided RAM address window and streams the words out
// Credit-based read issue keeps FIFO plus in-flight reads within FIFO_DEPTH.
module dram_stream_reader #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 20,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;
  state_t state, state_n;

  logic [ADDR_W-1:0] cur_addr, stride_r;
  logic [CNT_W-1:0]  count_r, issue_left, out_idx;
  logic [RD_LAT-1:0] pipe;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt, inflight;
  logic              hs, cap, issue_ok;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe[i]);
  end

  assign cap       = pipe[RD_LAT-1];
  assign out_valid = (fifo_cnt != '0);
  assign hs        = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_last  = out_valid && (out_idx == (count_r - CNT_W'(1)));
  assign ram_addr  = cur_addr;
  // A slot being popped this cycle is already free for a new read.
  assign issue_ok  = (fifo_cnt + inflight) < (CW'(FIFO_DEPTH) + CW'(hs));
  assign ram_en    = (state == S_RUN) && (issue_left != '0) && issue_ok;
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_FIN);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = (count != '0) ? S_RUN : S_FIN;
      S_RUN:   if (ram_en && issue_left == CNT_W'(1)) state_n = S_DRAIN;
      S_DRAIN: if (hs && out_last) state_n = S_FIN;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      stride_r   <= '0;
      count_r    <= '0;
      issue_left <= '0;
      out_idx    <= '0;
      pipe       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      state <= state_n;
      if (hs) out_idx <= out_idx + CNT_W'(1);
      if (state == S_IDLE && start) begin
        cur_addr   <= base_addr;
        stride_r   <= stride;
        count_r    <= count;
        issue_left <= count;
        out_idx    <= '0;
      end else if (ram_en) begin
        cur_addr   <= cur_addr + stride_r;
        issue_left <= issue_left - CNT_W'(1);
      end
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= ram_en;
      if (cap) wr_ptr <= wr_ptr + PW'(1);
      if (hs) rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(cap) - CW'(hs);
    end
  end

  always_ff @(posedge clk) begin
    if (cap) mem[wr_ptr] <= ram_rdata;
  end

endmodule

// File: tb/tb_dram_stream_reader.sv
// tb/tb_dram_stream_reader.sv - drives three reader configurations with shared stimulus against a window model
module tb_dram_stream_reader;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [18:0] base_addr = '0;
  logic [18:0] stride = '0;
  logic [19:0] count = '0;

  logic [18:0] ram_addr_v [N];
  logic [7:0]  ram_rdata_v [N];
  logic [7:0]  out_data_v [N];
  logic        ram_en_v [N], busy_v [N], done_v [N], out_valid_v [N], out_last_v [N];
  logic [7:0]  dpipe [N][4];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int e0 = 0;
  int rmode = 0;

  logic [7:0]  got [N][$];
  logic        lastf [N][$];
  logic [18:0] addrs [N][$];
  int n_en [N], n_hs [N], first_en [N], first_val [N], first_hs [N], last_hs [N];
  int done_cnt [N], done_cyc [N], max_occ [N], stall_err [N];
  logic       pv [N], pr [N];
  logic [7:0] pd [N];

  function automatic int lat_of(int k);
    return (k == 1) ? 3 : 1;
  endfunction
  function automatic int dep_of(int k);
    return (k == 2) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : 1;
    localparam int DEP = (g == 2) ? 2 : 4;
    dram_stream_reader #(.ADDR_W(19), .DATA_W(8), .CNT_W(20), .RD_LAT(LAT), .FIFO_DEPTH(DEP)) u_dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
      .stride(stride), .busy(busy_v[g]), .done(done_v[g]), .ram_addr(ram_addr_v[g]),
      .ram_en(ram_en_v[g]), .ram_rdata(ram_rdata_v[g]), .out_data(out_data_v[g]),
      .out_valid(out_valid_v[g]), .out_ready(out_ready), .out_last(out_last_v[g]));
    assign ram_rdata_v[g] = dpipe[g][LAT-1];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM word is the low address byte; idle slots carry a marker so mistimed captures show up.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      for (int i = 3; i > 0; i--) dpipe[k][i] <= dpipe[k][i-1];
      dpipe[k][0] <= ram_en_v[k] ? ram_addr_v[k][7:0] : 8'hA5;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (ram_en_v[k]) begin
        addrs[k].push_back(ram_addr_v[k]);
        n_en[k]++;
        if (first_en[k] < 0) first_en[k] = cyc;
      end
      if (out_valid_v[k] && first_val[k] < 0) first_val[k] = cyc;
      if (out_valid_v[k] && out_ready) begin
        got[k].push_back(out_data_v[k]);
        lastf[k].push_back(out_last_v[k]);
        n_hs[k]++;
        if (first_hs[k] < 0) first_hs[k] = cyc;
        last_hs[k] = cyc;
      end
      if (n_en[k] - n_hs[k] > max_occ[k]) max_occ[k] = n_en[k] - n_hs[k];
      if (done_v[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
      if (pv[k] && !pr[k] && (!out_valid_v[k] || out_data_v[k] !== pd[k])) stall_err[k]++;
      pv[k] = out_valid_v[k];
      pr[k] = out_ready;
      pd[k] = out_data_v[k];
    end
  end

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic clear();
    for (int k = 0; k < N; k++) begin
      got[k].delete();
      lastf[k].delete();
      addrs[k].delete();
      n_en[k] = 0; n_hs[k] = 0; first_en[k] = -1; first_val[k] = -1;
      first_hs[k] = -1; last_hs[k] = -1; done_cnt[k] = 0; done_cyc[k] = -1;
      max_occ[k] = 0; stall_err[k] = 0; pv[k] = 1'b0; pr[k] = 1'b0;
    end
  endtask

  task automatic drive_ready(input int st);
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = (st >= 20);
    endcase
  endtask

  function automatic bit all_done();
    for (int k = 0; k < N; k++) if (done_cnt[k] < 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic start_xfer(input logic [18:0] b, input logic [19:0] c, input logic [18:0] s);
    @(posedge clk);
    #1 clear();
    base_addr = b; count = c; stride = s; start = 1'b1;
    drive_ready(0);
    @(posedge clk);
    #1 e0 = cyc;
    start = 1'b0;
    drive_ready(0);
  endtask

  task automatic wait_done(input int dbl_step);
    for (int st = 1; st < 3000 && !all_done(); st++) begin
      @(posedge clk);
      #1 drive_ready(st);
      start = (st == dbl_step);
      if (st == dbl_step) begin
        base_addr = 19'h12345; count = 20'd50; stride = 19'd9;
      end
    end
    chk("timeout", 0, 64'(all_done()), 64'd1);
    for (int st = 0; st < 4; st++) begin
      @(posedge clk);
      #1 out_ready = 1'b1;
      start = 1'b0;
    end
  endtask

  task automatic check_xfer(input longint b, input longint c, input longint s);
    longint a;
    int m;
    for (int k = 0; k < N; k++) begin
      chk("len", k, 64'(got[k].size()), 64'(c));
      chk("addr_len", k, 64'(addrs[k].size()), 64'(c));
      m = (got[k].size() < int'(c)) ? got[k].size() : int'(c);
      for (int i = 0; i < m; i++) begin
        a = (b + longint'(i) * s) % 524288;
        chk("data", k, 64'(got[k][i]), 64'(a % 256));
        chk("last", k, 64'(lastf[k][i]), 64'(i == c - 1));
        if (i < addrs[k].size()) chk("addr", k, 64'(addrs[k][i]), 64'(a));
      end
      chk("done_cnt", k, 64'(done_cnt[k]), 64'd1);
      if (c > 0) chk("done_cyc", k, 64'(done_cyc[k]), 64'(last_hs[k] + 1));
      else begin
        chk("done_cyc0", k, 64'(done_cyc[k]), 64'(e0));
        chk("no_en", k, 64'(n_en[k]), 64'd0);
        chk("no_valid", k, 64'(first_val[k]), -64'sd1);
      end
      chk("occupancy", k, 64'(max_occ[k] <= dep_of(k)), 64'd1);
      chk("stall", k, 64'(stall_err[k]), 64'd0);
      if (rmode == 0 && c > 0) begin
        chk("first_en", k, 64'(first_en[k]), 64'(e0));
        chk("first_valid", k, 64'(first_val[k]), 64'(e0 + 1 + lat_of(k)));
        chk("throughput", k, 64'(last_hs[k] - first_hs[k]), 64'(c - 1));
      end
    end
  endtask

  task automatic xfer(input logic [18:0] b, input logic [19:0] c, input logic [18:0] s,
                      input int mode, input int dbl);
    rmode = mode;
    start_xfer(b, c, s);
    wait_done(dbl);
    check_xfer(longint'(b), longint'(c), longint'(s));
  endtask

  initial begin
    logic [18:0] rb, rs;
    logic [19:0] rc;
    clear();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      chk("reset_out", k, 64'({busy_v[k], done_v[k], ram_en_v[k], ram_addr_v[k], out_valid_v[k],
                               out_last_v[k], out_data_v[k]}), 64'd0);
    reset = 1'b0;

    xfer(19'd140, 20'd131, 19'd1, 0, -1);
    xfer(19'd140, 20'd131, 19'd1, 1, -1);
    xfer(19'h7FFFE, 20'd4, 19'd1, 0, -1);
    xfer(19'd77, 20'd0, 19'd3, 0, -1);
    xfer(19'd7, 20'd10, 19'd3, 0, 3);

    rmode = 0;
    start_xfer(19'd100, 20'd20, 19'd1);
    for (int t = 0; t < 200 && n_hs[0] < 5; t++) @(posedge clk);
    chk("five_hs", 0, 64'(n_hs[0] >= 5), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      chk("abort_out", k, 64'({busy_v[k], done_v[k], ram_en_v[k], ram_addr_v[k], out_valid_v[k],
                               out_last_v[k], out_data_v[k]}), 64'd0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) chk("abort_nodone", k, 64'(done_cnt[k]), 64'd0);

    xfer(19'd0, 20'd3, 19'd4, 0, -1);
    xfer(19'd33, 20'd12, 19'd5, 2, -1);
    xfer(19'd500, 20'd25, 19'd0, 1, -1);
    for (int r = 0; r < 3; r++) begin
      rb = 19'($urandom);
      rs = 19'($urandom);
      rc = 20'($urandom_range(1, 40));
      xfer(rb, rc, rs, 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dram_stream_reader.md
Name: dram_stream_reader

Overview:
- Synthesizable readout engine for the data RAM of the downsampling processor.
- After the processor reports completion, it walks a programmable address window (base, element count, stride) through a synchronous-read RAM port.
- Streams the bytes out over a valid/ready interface with back-pressure.
- Replaces address-by-address host polling of dRamAddr/dRamOut. Generalised in address width, data width, RAM read latency and buffer depth.

Parameters:
- ADDR_W, 19, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, RAM word and stream data width.
- CNT_W, 20, width of the element-count input.
- RD_LAT, 1, RAM read latency in cycles; legal values 1..4.
- FIFO_DEPTH, 4, output buffer entries; must be at least RD_LAT+1 and a power of two.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  ADDR_W  first RAM address; sampled with start.
- count  in  CNT_W  number of elements to read; sampled with start.
- stride  in  ADDR_W  address increment per element; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last element handshake.
- ram_addr  out  ADDR_W  RAM read address (dRamAddr).
- ram_en  out  1  read strobe; high for each issued read.
- ram_rdata  in  DATA_W  RAM read data (dRamOut); valid RD_LAT cycles after ram_en.
- out_data  out  DATA_W  stream data; driven from the FIFO head.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.
- out_last  out  1  high with the final element of the transfer.

Behaviour:
- Reset values: busy=0, done=0, ram_en=0, ram_addr=0, out_valid=0, out_last=0, out_data=0. FSM in IDLE, FIFO empty, in-flight pipe cleared. Reset mid-transfer aborts immediately: no done pulse, and in-flight RAM data is discarded.
- FSM states:
  - IDLE: on start with count!=0, latch base/count/stride and go to RUN. On start with count==0, go to DONE.
  - RUN: issue reads until all count addresses are issued, then go to DRAIN.
  - DRAIN: wait until the last element is handshaken, then go to DONE.
  - DONE: assert done for one cycle, then return to IDLE.
- busy=1 in RUN and DRAIN, 0 otherwise.
- start while not in IDLE is ignored; latched parameters are unaffected.
- Issue rule: in RUN, ram_en=1 when remaining_issue>0 and credits>0.
  - credits = FIFO_DEPTH - fifo_count - inflight.
  - inflight is the number of ram_en pulses whose data has not yet been captured.
  - ram_addr equals the current address whenever ram_en=1. After each issue, the address advances by stride, modulo 2^ADDR_W, with no carry out.
- Capture: a shift register of RD_LAT valid bits tracks issued reads. When the bit at depth RD_LAT is set, ram_rdata is written into the FIFO on that edge. Overflow is impossible by the credit rule; the bench asserts it never occurs.
- Output: out_valid = FIFO not empty. Handshake = out_valid & out_ready. out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- out_last is high when the FIFO head is element index count-1, tracked by an element counter on handshakes.
- Latency: start accepted at edge E0; first ram_en is in the cycle after E0; first out_valid is in the cycle after edge E0+1+RD_LAT.
- Throughput: with out_ready held at 1 and FIFO_DEPTH >= RD_LAT+1, the reader sustains one element per cycle.
- Completion: done pulses, and busy falls, in the cycle after the handshake that carries out_last.
- Simultaneous FIFO write and read in one cycle is legal at any occupancy, including full (the read frees the slot) and empty (the written word is not visible until the next cycle).
- Width rules:
  - count is treated as unsigned.
  - count = 2^CNT_W - 1 must work.
  - stride = 0 repeatedly reads base_addr.

Test Plan:
- RAM model with RD_LAT=1, word = addr[7:0]. start with base=140, count=131, stride=1, out_ready=1 → out_data 140..270 (mod 256), one per cycle. First out_valid at E0+2. out_last on 270. done one cycle later.
- Same transfer with out_ready toggling pseudo-randomly → identical 131-element sequence; no drops or duplicates; data stable under stall; FIFO never overflows.
- base=2^19-2, count=4, stride=1, RD_LAT=3 → ram_addr 524286, 524287, 0, 1. Stream is the corresponding four bytes in order.
- count=0 → no ram_en, no out_valid; done pulses in the second cycle after start. A start during busy of a count=10 transfer → ignored; exactly 10 elements emitted.
- Reset asserted mid-transfer after 5 handshakes → next cycle all outputs are at reset values and no done pulse. A fresh start afterwards (base=0, count=3, stride=4) → addresses 0, 4, 8 and 3 elements.
- FIFO_DEPTH=2, RD_LAT=1 with out_ready=0 for 20 cycles → at most 2 outstanding reads. Release ready → remaining elements delivered in order.
